// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, ALUOp codes, opcodes
// and small decode helpers used by the controller.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StIExec  = 4'd8,
    StIWb    = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11,
    StJReg   = 4'd12
  } state_e;

  localparam logic [3:0] AluOpLs    = 4'd0;
  localparam logic [3:0] AluOpRtype = 4'd1;
  localparam logic [3:0] AluOpBeq   = 4'd2;
  localparam logic [3:0] AluOpBne   = 4'd3;
  localparam logic [3:0] AluOpAddi  = 4'd4;
  localparam logic [3:0] AluOpAndi  = 4'd5;
  localparam logic [3:0] AluOpOri   = 4'd6;
  localparam logic [3:0] AluOpXori  = 4'd7;
  localparam logic [3:0] AluOpSlti  = 4'd8;
  localparam logic [3:0] AluOpSltiu = 4'd9;
  localparam logic [3:0] AluOpLui   = 4'd10;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpLh    = 6'b100001;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpLbu   = 6'b100100;
  localparam logic [5:0] OpLhu   = 6'b100101;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnJalr = 6'b001001;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op inside {OpAddi, OpAndi, OpOri, OpXori, OpSlti, OpSltiu, OpLui};
  endfunction

  // R-type functions the ALU implements (shifts, add/sub, logic, set-less-than).
  function automatic logic is_rtype_alu(input logic [5:0] funct);
    return funct inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                         6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                         6'b100110, 6'b100111, 6'b101010, 6'b101011};
  endfunction

  function automatic logic zero_ext(input logic [5:0] op);
    return op inside {OpAndi, OpOri, OpXori};
  endfunction

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    logic [3:0] aop;
    case (op)
      OpAddi:  aop = AluOpAddi;
      OpAndi:  aop = AluOpAndi;
      OpOri:   aop = AluOpOri;
      OpXori:  aop = AluOpXori;
      OpSlti:  aop = AluOpSlti;
      OpSltiu: aop = AluOpSltiu;
      OpLui:   aop = AluOpLui;
      default: aop = AluOpLs;
    endcase
    return aop;
  endfunction

  // Unknown opcodes and unknown R-type functions fall back to FETCH with nothing written.
  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] funct);
    state_e nxt;
    nxt = StFetch;
    if (op == OpRtype) begin
      if (funct inside {FnJr, FnJalr}) nxt = StJReg;
      else if (is_rtype_alu(funct))    nxt = StRExec;
    end else if (is_load(op) || op == OpSw) begin
      nxt = StMemAdr;
    end else if (is_imm(op)) begin
      nxt = StIExec;
    end else if (op inside {OpBeq, OpBne}) begin
      nxt = StBranch;
    end else if (op inside {OpJ, OpJal}) begin
      nxt = StJump;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Saturating wait-state counter; expire_o flags that Limit waits have elapsed (Limit=0 never).
module mc_mem_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned Width = (Limit > 0) ? $clog2(Limit + 1) : 1;
  localparam logic [Width-1:0] CntMax = (Limit > 0) ? Width'(Limit) : {Width{1'b1}};

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && count_q != CntMax) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire_o = (Limit != 0) && (count_q == CntMax);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction and drives
// ALUOp plus datapath strobes, with a timed mem_ready handshake on memory accesses.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   waiting, timer_expire, timer_clr, abort;

  // Zero is consumed by the datapath's PC-enable gate, not by the controller.
  logic unused_zero;
  assign unused_zero = Zero;

  assign waiting   = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;
  assign abort     = waiting && timer_expire;
  assign timer_clr = (state_d != state_q) || abort;

  mc_mem_timer #(
    .Limit(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (timer_clr),
    .en_i    (waiting),
    .expire_o(timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: state_d = decode_next(Op, Funct);
      StMemAdr: state_d = (Op == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StRExec:  state_d = StRWb;
      StIExec:  state_d = StIWb;
      default:  state_d = StFetch;
    endcase
    if (abort) state_d = StFetch;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ExtOp       = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = AluOpLs;
    mem_err     = 1'b0;
    // Reset holds every strobe and select low regardless of the registered state.
    if (!rst) begin
      ExtOp   = !zero_ext(Op);
      mem_err = abort;
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        StDecode: ALUSrcB = 2'b11;
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        StMemWr: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StRExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = AluOpRtype;
        end
        StRWb: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end
        StIExec: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = imm_alu_op(Op);
        end
        StIWb: RegWrite = 1'b1;
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = (Op == OpBne) ? AluOpBne : AluOpBeq;
          PCWriteCond = 1'b1;
          BranchNe    = (Op == OpBne);
          PCSource    = 2'b01;
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          if (Op == OpJal) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end
        StJReg: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          if (Funct == FnJalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            MemtoReg = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule
